// File: rtl/mem_access_ctrl_if.sv
// Shared types plus the pipeline-side and bus-side interfaces of the
// memory-stage load/store sequencer.
package mem_access_ctrl_pkg;
    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        RESP  = 2'd3
    } state_t;
endpackage

// Handshakes: a request transfers on the rising edge where req_valid && req_ready;
// resp_valid is a one-cycle pulse with no back-pressure. A bus beat holds all
// dreq_* stable while dreq_valid is high and completes on the edge where dresp_ok is high.
interface mem_req_if;
    logic                        req_valid;
    logic                        req_ready;
    logic [63:0]                 req_addr;
    logic                        req_write;
    mem_access_ctrl_pkg::msize_t req_msize;
    logic                        req_unsigned;
    logic [63:0]                 req_wdata;
    logic                        resp_valid;
    logic [63:0]                 resp_rdata;
    logic                        resp_misalign;

    modport master (
        output req_valid, req_addr, req_write, req_msize, req_unsigned, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_misalign
    );
    modport slave (
        input  req_valid, req_addr, req_write, req_msize, req_unsigned, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_misalign
    );
endinterface

interface mem_bus_if;
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    logic        dreq_write;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;
    logic        dresp_ok;
    logic [63:0] dresp_data;

    modport master (
        output dreq_valid, dreq_addr, dreq_write, dreq_strobe, dreq_data,
        input  dresp_ok, dresp_data
    );
    modport slave (
        input  dreq_valid, dreq_addr, dreq_write, dreq_strobe, dreq_data,
        output dresp_ok, dresp_data
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory-stage load/store sequencer: turns one pipeline access into one or two
// aligned 8-byte bus beats and returns a single extended load result.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic      clk,
    input  logic      resetn,
    mem_req_if.slave  req,
    mem_bus_if.master bus,
    output state_t    state_dbg
);

    state_t       state_q, state_d;
    logic [60:0]  base_q;
    logic [2:0]   off_q;
    msize_t       size_q;
    logic         write_q;
    logic         unsigned_q;
    logic         cross_q;
    logic         misalign_q;
    logic [15:0]  strobe_q;
    logic [127:0] wvec_q;
    logic [63:0]  lo_q;
    logic [63:0]  hi_q;

    logic [2:0]   off_in;
    logic [3:0]   nbytes_in;
    logic         cross_in;
    logic [15:0]  strobe_in;
    logic [127:0] wvec_in;
    logic         accept;
    logic [63:0]  field;
    logic         sext;
    logic [63:0]  load_val;

    // Strobe and write data are laid out over a 16-byte window so a split
    // access just takes the upper half on the second beat.
    always_comb begin
        off_in    = req.req_addr[2:0];
        nbytes_in = 4'd1;
        case (req.req_msize)
            MSIZE1:  nbytes_in = 4'd1;
            MSIZE2:  nbytes_in = 4'd2;
            MSIZE4:  nbytes_in = 4'd4;
            MSIZE8:  nbytes_in = 4'd8;
            default: nbytes_in = 4'd1;
        endcase
        strobe_in = ((16'd1 << nbytes_in) - 16'd1) << off_in;
        wvec_in   = {64'd0, req.req_wdata} << {off_in, 3'b000};
        cross_in  = ({1'b0, off_in} + nbytes_in) > 4'd8;
    end

    assign accept = (state_q == IDLE) && req.req_valid;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req.req_valid) begin
                    state_d = (cross_in && !ALLOW_MISALIGNED) ? RESP : BEAT0;
                end
            end
            BEAT0: begin
                if (bus.dresp_ok) begin
                    state_d = cross_q ? BEAT1 : RESP;
                end
            end
            BEAT1: begin
                if (bus.dresp_ok) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            base_q     <= '0;
            off_q      <= '0;
            size_q     <= MSIZE1;
            write_q    <= 1'b0;
            unsigned_q <= 1'b0;
            cross_q    <= 1'b0;
            misalign_q <= 1'b0;
            strobe_q   <= '0;
            wvec_q     <= '0;
            lo_q       <= '0;
            hi_q       <= '0;
        end else begin
            if (accept) begin
                base_q     <= req.req_addr[63:3];
                off_q      <= off_in;
                size_q     <= req.req_msize;
                write_q    <= req.req_write;
                unsigned_q <= req.req_unsigned;
                cross_q    <= cross_in;
                misalign_q <= cross_in && !ALLOW_MISALIGNED;
                strobe_q   <= strobe_in;
                wvec_q     <= wvec_in;
                lo_q       <= '0;
                hi_q       <= '0;
            end
            if ((state_q == BEAT0) && bus.dresp_ok && !write_q) begin
                lo_q <= bus.dresp_data;
            end
            if ((state_q == BEAT1) && bus.dresp_ok && !write_q) begin
                hi_q <= bus.dresp_data;
            end
        end
    end

    // The addressed field starts at byte off of the merged beats; hi stays zero
    // for single-beat loads and is truncated away anyway.
    always_comb begin
        field    = 64'({hi_q, lo_q} >> {off_q, 3'b000});
        sext     = !unsigned_q;
        load_val = field;
        case (size_q)
            MSIZE1:  load_val = {{56{sext & field[7]}},  field[7:0]};
            MSIZE2:  load_val = {{48{sext & field[15]}}, field[15:0]};
            MSIZE4:  load_val = {{32{sext & field[31]}}, field[31:0]};
            default: load_val = field;
        endcase
    end

    always_comb begin
        req.req_ready     = (state_q == IDLE);
        req.resp_valid    = (state_q == RESP);
        req.resp_misalign = (state_q == RESP) && misalign_q;
        req.resp_rdata    = ((state_q == RESP) && !write_q && !misalign_q) ? load_val : 64'd0;

        bus.dreq_valid  = 1'b0;
        bus.dreq_addr   = 64'd0;
        bus.dreq_write  = 1'b0;
        bus.dreq_strobe = 8'd0;
        bus.dreq_data   = 64'd0;
        case (state_q)
            BEAT0: begin
                bus.dreq_valid  = 1'b1;
                bus.dreq_addr   = {base_q, 3'b000};
                bus.dreq_write  = write_q;
                bus.dreq_strobe = strobe_q[7:0];
                bus.dreq_data   = wvec_q[63:0];
            end
            BEAT1: begin
                bus.dreq_valid  = 1'b1;
                bus.dreq_addr   = {base_q + 61'd1, 3'b000};
                bus.dreq_write  = write_q;
                bus.dreq_strobe = strobe_q[15:8];
                bus.dreq_data   = wvec_q[127:64];
            end
            default: begin
            end
        endcase
    end

    assign state_dbg = state_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl: byte-memory reference model, bus
// responder with its own memory, directed boundary cases and a reset abort.
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  mem_req_if req_if ();
  mem_bus_if bus_if ();
  mem_req_if req_na ();
  mem_bus_if bus_na ();
  state_t dbg;
  state_t dbg_na;

  mem_access_ctrl #(.ALLOW_MISALIGNED(1'b1)) dut (
    .clk(clk), .resetn(resetn), .req(req_if), .bus(bus_if), .state_dbg(dbg)
  );
  mem_access_ctrl #(.ALLOW_MISALIGNED(1'b0)) dut_na (
    .clk(clk), .resetn(resetn), .req(req_na), .bus(bus_na), .state_dbg(dbg_na)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [7:0]  bus_mem [256];
  logic [7:0]  ref_mem [256];
  logic [63:0] exp_q [$];
  logic [63:0] exp_baddr_q [$];
  logic [7:0]  exp_bstrobe_q [$];
  logic [63:0] exp_bdata_q [$];
  logic [63:0] obs_baddr_q [$];
  logic [7:0]  obs_bstrobe_q [$];
  logic [63:0] obs_bdata_q [$];
  logic        obs_bwrite_q [$];
  int          fixed_delay = 0;
  int          wait_total = 0;
  int          exp_nbeats = 0;
  logic        exp_wr = 1'b0;
  int          na_dreq_seen = 0;
  logic [63:0] last_rdata;
  int          last_cycles;
  logic [63:0] last_baddr [2];
  logic [7:0]  last_bstrobe [2];
  logic [63:0] last_bdata [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- bus responder ----------------
  initial begin : responder
    logic        in_beat;
    int          wait_left;
    logic [63:0] c_addr;
    logic [63:0] c_data;
    logic [7:0]  c_strobe;
    logic        c_write;
    logic [7:0]  idx;
    in_beat = 1'b0;
    wait_left = 0;
    c_addr = '0; c_data = '0; c_strobe = '0; c_write = 1'b0;
    bus_if.dresp_ok = 1'b0;
    bus_if.dresp_data = '0;
    forever begin
      @(negedge clk);
      bus_if.dresp_ok = 1'b0;
      if (!resetn) begin
        in_beat = 1'b0;
      end else if (bus_if.dreq_valid) begin
        if (!in_beat) begin
          in_beat = 1'b1;
          c_addr = bus_if.dreq_addr;
          c_data = bus_if.dreq_data;
          c_strobe = bus_if.dreq_strobe;
          c_write = bus_if.dreq_write;
          obs_baddr_q.push_back(c_addr);
          obs_bstrobe_q.push_back(c_strobe);
          obs_bdata_q.push_back(c_data);
          obs_bwrite_q.push_back(c_write);
          wait_left = (fixed_delay < 0) ? $urandom_range(0, 3) : fixed_delay;
        end else begin
          check("dreq_stable_addr", bus_if.dreq_addr, c_addr);
          check("dreq_stable_strobe", 64'(bus_if.dreq_strobe), 64'(c_strobe));
          check("dreq_stable_data", bus_if.dreq_data, c_data);
          check("dreq_stable_write", 64'(bus_if.dreq_write), 64'(c_write));
        end
        if (wait_left == 0) begin
          for (int l = 0; l < 8; l++) begin
            idx = c_addr[7:0] + 8'(l);
            bus_if.dresp_data[8*l +: 8] = bus_mem[idx];
            if (c_write && c_strobe[l]) bus_mem[idx] = c_data[8*l +: 8];
          end
          bus_if.dresp_ok = 1'b1;
          in_beat = 1'b0;
        end else begin
          wait_left--;
          wait_total++;
        end
      end
    end
  end

  always @(negedge clk) if (bus_na.dreq_valid) na_dreq_seen++;

  // ---------------- driver tasks + reference model ----------------
  task automatic set_mem(input logic [63:0] addr, input logic [63:0] val);
    logic [7:0] idx;
    for (int i = 0; i < 8; i++) begin
      idx = addr[7:0] + 8'(i);
      bus_mem[idx] = val[8*i +: 8];
      ref_mem[idx] = val[8*i +: 8];
    end
  endtask

  task automatic start_req(input logic [63:0] addr, input msize_t msize, input logic wr,
                           input logic uns, input logic [63:0] wdata);
    int          n;
    int          b;
    int          lane;
    logic [63:0] a;
    logic [63:0] v;
    logic [7:0]  idx;
    logic [7:0]  es [2];
    logic [63:0] ed [2];
    n = 1 << int'(msize);
    es[0] = '0; es[1] = '0; ed[0] = '0; ed[1] = '0;
    exp_nbeats = 1;
    v = '0;
    for (int i = 0; i < n; i++) begin
      a = addr + 64'(i);
      b = (a[63:3] != addr[63:3]) ? 1 : 0;
      lane = int'(a[2:0]);
      es[b][lane] = 1'b1;
      ed[b][8*lane +: 8] = wdata[8*i +: 8];
      if (b + 1 > exp_nbeats) exp_nbeats = b + 1;
      idx = addr[7:0] + 8'(i);
      if (wr) ref_mem[idx] = wdata[8*i +: 8];
      else v[8*i +: 8] = ref_mem[idx];
    end
    if (!wr && !uns && n < 8 && v[8*n-1]) begin
      for (int j = 8 * n; j < 64; j++) v[j] = 1'b1;
    end
    for (int k = 0; k < exp_nbeats; k++) begin
      exp_baddr_q.push_back({addr[63:3], 3'b000} + 64'(8 * k));
      exp_bstrobe_q.push_back(es[k]);
      exp_bdata_q.push_back(ed[k]);
    end
    exp_q.push_back(wr ? 64'd0 : v);
    exp_wr = wr;

    @(negedge clk);
    for (int t = 0; t < 50 && !req_if.req_ready; t++) @(negedge clk);
    check("req_ready_idle", 64'(req_if.req_ready), 64'd1);
    req_if.req_addr = addr;
    req_if.req_msize = msize;
    req_if.req_write = wr;
    req_if.req_unsigned = uns;
    req_if.req_wdata = wdata;
    req_if.req_valid = 1'b1;
    wait_total = 0;
    @(posedge clk);
    #1 req_if.req_valid = 1'b0;
  endtask

  task automatic finish_req(input int poke);
    int          cycles;
    logic        got;
    int          pk;
    logic [63:0] m;
    logic [63:0] ob;
    logic [7:0]  os;
    logic        ow;
    cycles = 0;
    got = 1'b0;
    pk = poke;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (req_if.resp_valid) begin
        got = 1'b1;
        break;
      end
      check("busy_not_ready", 64'(req_if.req_ready), 64'd0);
      if (pk > 0) begin
        req_if.req_valid = 1'b1;
        req_if.req_addr = 64'h5000;
        pk--;
      end else begin
        req_if.req_valid = 1'b0;
      end
      @(posedge clk);
      cycles++;
    end
    req_if.req_valid = 1'b0;
    last_cycles = cycles;
    last_baddr[0] = '0; last_baddr[1] = '0;
    last_bstrobe[0] = '0; last_bstrobe[1] = '0;
    last_bdata[0] = '0; last_bdata[1] = '0;
    if (!got) begin
      check("resp_timeout", 64'(req_if.resp_valid), 64'd1);
    end else begin
      last_rdata = req_if.resp_rdata;
      if (exp_q.size() > 0) check("resp_rdata", req_if.resp_rdata, exp_q.pop_front());
      check("resp_misalign", 64'(req_if.resp_misalign), 64'd0);
      check("resp_ready_low", 64'(req_if.req_ready), 64'd0);
      check("latency", 64'(cycles), 64'(exp_nbeats + wait_total));
      check("beat_count", 64'(obs_baddr_q.size()), 64'(exp_baddr_q.size()));
      for (int k = 0; k < 2 && obs_baddr_q.size() > 0 && exp_baddr_q.size() > 0; k++) begin
        ob = obs_bdata_q.pop_front();
        os = obs_bstrobe_q.pop_front();
        ow = obs_bwrite_q.pop_front();
        last_baddr[k] = obs_baddr_q.pop_front();
        last_bstrobe[k] = os;
        last_bdata[k] = ob;
        check("beat_addr", last_baddr[k], exp_baddr_q.pop_front());
        check("beat_strobe", 64'(os), 64'(exp_bstrobe_q.pop_front()));
        check("beat_write", 64'(ow), 64'(exp_wr));
        m = '0;
        for (int l = 0; l < 8; l++) if (os[l]) m[8*l +: 8] = 8'hFF;
        if (exp_wr) check("beat_wdata", ob & m, exp_bdata_q.pop_front());
        else void'(exp_bdata_q.pop_front());
      end
    end
    exp_q.delete();
    exp_baddr_q.delete(); exp_bstrobe_q.delete(); exp_bdata_q.delete();
    obs_baddr_q.delete(); obs_bstrobe_q.delete(); obs_bdata_q.delete(); obs_bwrite_q.delete();
    @(negedge clk);
    check("resp_pulse_end", 64'(req_if.resp_valid), 64'd0);
    check("ready_after_resp", 64'(req_if.req_ready), 64'd1);
  endtask

  task automatic do_req(input logic [63:0] addr, input msize_t msize, input logic wr,
                        input logic uns, input logic [63:0] wdata, input int poke);
    start_req(addr, msize, wr, uns, wdata);
    finish_req(poke);
  endtask

  task automatic na_req(input logic [63:0] addr, input msize_t msize, input logic wr);
    @(negedge clk);
    check("na_ready", 64'(req_na.req_ready), 64'd1);
    req_na.req_addr = addr;
    req_na.req_msize = msize;
    req_na.req_write = wr;
    req_na.req_unsigned = 1'b0;
    req_na.req_wdata = 64'h0102_0304_0506_0708;
    req_na.req_valid = 1'b1;
    @(posedge clk);
    #1 req_na.req_valid = 1'b0;
    @(negedge clk);
    check("na_resp_valid", 64'(req_na.resp_valid), 64'd1);
    check("na_resp_misalign", 64'(req_na.resp_misalign), 64'd1);
    check("na_resp_rdata", req_na.resp_rdata, 64'd0);
    @(negedge clk);
    check("na_resp_pulse_end", 64'(req_na.resp_valid), 64'd0);
    check("na_back_idle", 64'(dbg_na), 64'(IDLE));
    check("na_no_dreq", 64'(na_dreq_seen), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 64'(req_if.req_ready), 64'd1);
    check({tag, "_resp_valid"}, 64'(req_if.resp_valid), 64'd0);
    check({tag, "_resp_rdata"}, req_if.resp_rdata, 64'd0);
    check({tag, "_resp_misalign"}, 64'(req_if.resp_misalign), 64'd0);
    check({tag, "_dreq_valid"}, 64'(bus_if.dreq_valid), 64'd0);
    check({tag, "_dreq_addr"}, bus_if.dreq_addr, 64'd0);
    check({tag, "_dreq_write"}, 64'(bus_if.dreq_write), 64'd0);
    check({tag, "_dreq_strobe"}, 64'(bus_if.dreq_strobe), 64'd0);
    check({tag, "_dreq_data"}, bus_if.dreq_data, 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] r;
    resetn = 1'b0;
    req_if.req_valid = 1'b0; req_if.req_addr = '0; req_if.req_write = 1'b0;
    req_if.req_msize = MSIZE1; req_if.req_unsigned = 1'b0; req_if.req_wdata = '0;
    req_na.req_valid = 1'b0; req_na.req_addr = '0; req_na.req_write = 1'b0;
    req_na.req_msize = MSIZE1; req_na.req_unsigned = 1'b0; req_na.req_wdata = '0;
    bus_na.dresp_ok = 1'b0; bus_na.dresp_data = '0;
    for (int i = 0; i < 256; i++) begin
      r = 8'($urandom);
      bus_mem[i] = r;
      ref_mem[i] = r;
    end
    @(negedge clk);
    check_reset_outputs("reset");
    @(negedge clk);
    resetn = 1'b1;

    // Signed byte load, one beat
    fixed_delay = 0;
    set_mem(64'h1000, 64'h1111_1111_8011_1111);
    do_req(64'h1003, MSIZE1, 1'b0, 1'b0, 64'd0, 0);
    check("lb_rdata", last_rdata, 64'hFFFF_FFFF_FFFF_FF80);
    check("lb_addr", last_baddr[0], 64'h1000);
    check("lb_strobe", 64'(last_bstrobe[0]), 64'h08);
    check("lb_latency", 64'(last_cycles), 64'd1);

    // Unsigned word load crossing an 8-byte boundary
    set_mem(64'h1000, 64'hAABB_0000_0000_0000);
    set_mem(64'h1008, 64'h0000_0000_0000_CCDD);
    do_req(64'h1006, MSIZE4, 1'b0, 1'b1, 64'd0, 0);
    check("lwu_rdata", last_rdata, 64'h0000_0000_CCDD_AABB);
    check("lwu_addr0", last_baddr[0], 64'h1000);
    check("lwu_strobe0", 64'(last_bstrobe[0]), 64'hC0);
    check("lwu_addr1", last_baddr[1], 64'h1008);
    check("lwu_strobe1", 64'(last_bstrobe[1]), 64'h03);
    check("lwu_latency", 64'(last_cycles), 64'd2);

    // Halfword store split across two beats, then read back
    do_req(64'h2007, MSIZE2, 1'b1, 1'b0, 64'h1234, 0);
    check("sh_rdata", last_rdata, 64'd0);
    check("sh_strobe0", 64'(last_bstrobe[0]), 64'h80);
    check("sh_data0", 64'(last_bdata[0][63:56]), 64'h34);
    check("sh_addr1", last_baddr[1], 64'h2008);
    check("sh_strobe1", 64'(last_bstrobe[1]), 64'h01);
    check("sh_data1", 64'(last_bdata[1][7:0]), 64'h12);
    do_req(64'h2007, MSIZE2, 1'b0, 1'b1, 64'd0, 0);
    check("sh_readback", last_rdata, 64'h1234);

    // Aligned doubleword store with a slow bus and a request poked while busy
    fixed_delay = 5;
    do_req(64'h3000, MSIZE8, 1'b1, 1'b0, 64'hDEAD_BEEF_0BAD_F00D, 2);
    check("sd_latency", 64'(last_cycles), 64'd6);
    check("sd_strobe", 64'(last_bstrobe[0]), 64'hFF);
    fixed_delay = 0;
    do_req(64'h3000, MSIZE8, 1'b0, 1'b0, 64'd0, 0);
    check("sd_readback", last_rdata, 64'hDEAD_BEEF_0BAD_F00D);

    // Misaligned accesses rejected when splitting is disabled
    na_req(64'h4004, MSIZE8, 1'b0);
    na_req(64'h4007, MSIZE2, 1'b1);

    // Reset while the second beat of a crossing load is outstanding
    set_mem(64'h1000, 64'h0123_4567_89AB_CDEF);
    fixed_delay = 8;
    start_req(64'h1006, MSIZE8, 1'b0, 1'b0, 64'd0);
    for (int t = 0; t < 30 && dbg != BEAT1; t++) @(negedge clk);
    check("reached_beat1", 64'(dbg), 64'(BEAT1));
    #2 resetn = 1'b0;
    #1 check_reset_outputs("abort");
    check("abort_state", 64'(dbg), 64'(IDLE));
    exp_q.delete();
    exp_baddr_q.delete(); exp_bstrobe_q.delete(); exp_bdata_q.delete();
    obs_baddr_q.delete(); obs_bstrobe_q.delete(); obs_bdata_q.delete(); obs_bwrite_q.delete();
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    fixed_delay = 0;
    do_req(64'h1000, MSIZE8, 1'b0, 1'b0, 64'd0, 0);
    check("post_reset_rdata", last_rdata, 64'h0123_4567_89AB_CDEF);

    // Randomized traffic against the byte-memory model
    fixed_delay = -1;
    for (int i = 0; i < 200; i++) begin
      do_req({$urandom, $urandom}, msize_t'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), {$urandom, $urandom}, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
